sweep_stim_seq: RTL and testbench

//  Synthesizable, parametrised stimulus sequencer for on-board bring-up of the USB core.
//  On start: issues a DUT reset pulse, then a settle period, then walks a one-hot

---
 rtl/sweep_stim_pkg.sv | 24 ++
 rtl/sweep_stim_seq_cyc_timer.sv | 27 ++
 rtl/sweep_stim_seq.sv | 166 ++++++++++++++++
 tb/tb_sweep_stim_seq.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/sweep_stim_pkg.sv
// Shared types for the sweep stimulus sequencer.
package sweep_stim_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RST    = 3'd1,
        SETTLE = 3'd2,
        CH     = 3'd3,
        FINAL  = 3'd4,
        DONE   = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        SINGLE = 2'd0,
        LOOP   = 2'd1,
        MANUAL = 2'd2
    } mode_t;

    // Reserved mode code 3 behaves as SINGLE.
    function automatic mode_t decode_mode(input logic [1:0] raw);
        return (raw == 2'd3) ? SINGLE : mode_t'(raw);
    endfunction

endpackage

// File: rtl/sweep_stim_seq_cyc_timer.sv
// Down-counting dwell timer: load sets the count, expired flags terminal count zero.
module cyc_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             expired
);

    logic [CNT_W-1:0] r_cnt;

    // Reload on request, otherwise count down and park at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign expired = (r_cnt == '0);

endmodule

// File: rtl/sweep_stim_seq.sv
// Sweep stimulus sequencer: reset pulse, settle, one-hot channel walk, final off period.
//
// state  | meaning
// IDLE   | waiting for start, all outputs low
// RST    | rst_out high for RST_CYC cycles
// SETTLE | all-off for one dwell (or until step in MANUAL)
// CH     | ch_sel[idx] high for one dwell per channel
// FINAL  | all-off for one dwell (or until step in MANUAL)
// DONE   | one-cycle done pulse, pass_cnt increments
module sweep_stim_seq
    import sweep_stim_pkg::*;
#(
    parameter  int N_CH      = 4,
    parameter  int CNT_W     = 16,
    parameter  int DWELL_DEF = 72,
    parameter  int RST_CYC   = 3,
    localparam int IDX_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [1:0]       mode,
    input  logic             step,
    input  logic [CNT_W-1:0] dwell_cyc,
    output logic             rst_out,
    output logic [N_CH-1:0]  ch_sel,
    output logic [IDX_W-1:0] ch_idx,
    output logic             busy,
    output logic             done,
    output logic [7:0]       pass_cnt
);

    state_t           r_state;
    mode_t            r_mode;
    logic [CNT_W-1:0] r_eff;
    logic [IDX_W-1:0] r_idx;
    logic [N_CH-1:0]  r_ch_sel;
    logic             r_rst_out;
    logic             r_busy;
    logic             r_done;
    logic [7:0]       r_pass;

    logic             w_expired;
    logic             w_adv;
    logic             w_load;
    logic [CNT_W-1:0] w_load_val;

    // Timer reload whenever the state or channel index is about to change.
    // IDLE keeps the timer primed with the reset pulse length.
    always_comb begin
        w_adv      = (r_mode == MANUAL) ? step : w_expired;
        w_load     = 1'b0;
        w_load_val = r_eff - 1'b1;
        case (r_state)
            IDLE: begin
                w_load     = 1'b1;
                w_load_val = CNT_W'(RST_CYC - 1);
            end
            RST:                w_load = w_expired;
            SETTLE, CH, FINAL:  w_load = w_adv;
            DONE:               w_load = 1'b1;
            default:            w_load = 1'b1;
        endcase
    end

    cyc_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .rst      (reset),
        .load     (w_load),
        .load_val (w_load_val),
        .expired  (w_expired)
    );

    // Sequencer FSM with registered outputs; abort overrides everything but reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_mode    <= SINGLE;
            r_eff     <= CNT_W'(DWELL_DEF);
            r_idx     <= '0;
            r_ch_sel  <= '0;
            r_rst_out <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_pass    <= '0;
        end else if (abort) begin
            r_state   <= IDLE;
            r_idx     <= '0;
            r_ch_sel  <= '0;
            r_rst_out <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state   <= RST;
                        r_mode    <= decode_mode(mode);
                        r_eff     <= (dwell_cyc == '0) ? CNT_W'(DWELL_DEF) : dwell_cyc;
                        r_pass    <= '0;
                        r_rst_out <= 1'b1;
                        r_busy    <= 1'b1;
                    end
                end
                RST: begin
                    if (w_expired) begin
                        r_state   <= SETTLE;
                        r_rst_out <= 1'b0;
                    end
                end
                SETTLE: begin
                    if (w_adv) begin
                        r_state  <= CH;
                        r_idx    <= '0;
                        r_ch_sel <= N_CH'(1);
                    end
                end
                CH: begin
                    if (w_adv) begin
                        if (r_idx == IDX_W'(N_CH - 1)) begin
                            r_state  <= FINAL;
                            r_idx    <= '0;
                            r_ch_sel <= '0;
                        end else begin
                            r_idx    <= r_idx + 1'b1;
                            r_ch_sel <= r_ch_sel << 1;
                        end
                    end
                end
                FINAL: begin
                    if (w_adv) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                        r_pass  <= r_pass + 1'b1;
                    end
                end
                DONE: begin
                    if (r_mode == LOOP) begin
                        r_state  <= CH;
                        r_idx    <= '0;
                        r_ch_sel <= N_CH'(1);
                    end else begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= IDLE;
                    r_busy   <= 1'b0;
                    r_ch_sel <= '0;
                    r_idx    <= '0;
                end
            endcase
        end
    end

    assign rst_out  = r_rst_out;
    assign ch_sel   = r_ch_sel;
    assign ch_idx   = r_idx;
    assign busy     = r_busy;
    assign done     = r_done;
    assign pass_cnt = r_pass;

endmodule

// File: tb/tb_sweep_stim_seq.sv
// Directed bench for sweep_stim_seq with hand-computed expected timelines.
module tb_sweep_stim_seq;

    localparam int N_CH  = 4;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic             step = 1'b0;
    logic [1:0]       mode = 2'd0;
    logic [CNT_W-1:0] dwell_cyc = '0;
    logic             rst_out;
    logic [N_CH-1:0]  ch_sel;
    logic [1:0]       ch_idx;
    logic             busy;
    logic             done;
    logic [7:0]       pass_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sweep_stim_seq #(
        .N_CH      (4),
        .CNT_W     (16),
        .DWELL_DEF (72),
        .RST_CYC   (3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
        .mode      (mode),
        .step      (step),
        .dwell_cyc (dwell_cyc),
        .rst_out   (rst_out),
        .ch_sel    (ch_sel),
        .ch_idx    (ch_idx),
        .busy      (busy),
        .done      (done),
        .pass_cnt  (pass_cnt)
    );

    typedef struct {
        logic [CNT_W-1:0] dwell;
        logic [1:0]       mode;
        int               eff;
        bit               noise;
    } vec_t;

    vec_t vecs[4];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] pk(input int r, input int sel, input int idx,
                                       input int b, input int d, input int p);
        return {15'd0, r[0], sel[3:0], idx[1:0], b[0], d[0], p[7:0]};
    endfunction

    function automatic logic [31:0] obs();
        return {15'd0, rst_out, ch_sel, ch_idx, busy, done, pass_cnt};
    endfunction

    // Expected outputs k cycles after the start edge in a SINGLE run with dwell e.
    function automatic logic [31:0] exp_single(input int k, input int e);
        if (k < 3)         return pk(1, 0, 0, 1, 0, 0);
        if (k < 3 + e)     return pk(0, 0, 0, 1, 0, 0);
        for (int c = 0; c < 4; c++)
            if (k < 3 + e * (c + 2)) return pk(0, 1 << c, c, 1, 0, 0);
        if (k < 3 + e * 6) return pk(0, 0, 0, 1, 0, 0);
        if (k == 3 + e * 6) return pk(0, 0, 0, 1, 1, 1);
        return pk(0, 0, 0, 0, 0, 1);
    endfunction

    initial begin
        int n;
        int done_k;
        int len;
        int bound;

        vecs[0] = '{dwell: 16'd0, mode: 2'd0, eff: 72, noise: 1'b0};
        vecs[1] = '{dwell: 16'd1, mode: 2'd0, eff: 1,  noise: 1'b0};
        vecs[2] = '{dwell: 16'd5, mode: 2'd3, eff: 5,  noise: 1'b1};
        vecs[3] = '{dwell: 16'd2, mode: 2'd0, eff: 2,  noise: 1'b1};

        // Reset state
        tick();
        chk("reset_state", obs(), pk(0, 0, 0, 0, 0, 0));
        reset = 1'b0;
        tick();
        chk("idle_after_reset", obs(), pk(0, 0, 0, 0, 0, 0));

        // SINGLE sweeps, optionally with start/step/mode/dwell noise while busy
        for (int i = 0; i < 4; i++) begin
            mode      = vecs[i].mode;
            dwell_cyc = vecs[i].dwell;
            start     = 1'b1;
            tick();
            start  = 1'b0;
            done_k = 3 + 6 * vecs[i].eff;
            len    = done_k + 3;
            for (int k = 0; k < len; k++) begin
                chk($sformatf("single v%0d k=%0d", i, k), obs(), exp_single(k, vecs[i].eff));
                if (vecs[i].noise && (k % 5 == 2) && (k < done_k)) begin
                    start     = 1'b1;
                    step      = 1'b1;
                    mode      = 2'd2;
                    dwell_cyc = 16'd7;
                end else begin
                    start     = 1'b0;
                    step      = 1'b0;
                    mode      = vecs[i].mode;
                    dwell_cyc = vecs[i].dwell;
                end
                tick();
            end
            start = 1'b0;
            step  = 1'b0;
        end

        // LOOP, dwell 1: done every 6 cycles, pass_cnt wraps 255 -> 0
        mode      = 2'd1;
        dwell_cyc = 16'd1;
        start     = 1'b1;
        tick();
        start = 1'b0;
        n     = 0;
        bound = 3 + 6 * 257 + 20;
        for (int k = 0; k < bound && n < 257; k++) begin
            if (k >= 4 && k < 40 && ((k - 4) % 6) < 4)
                chk($sformatf("loop_sel k=%0d", k), {28'd0, ch_sel}, 32'(1 << ((k - 4) % 6)));
            if (done) begin
                if (n < 4 || n >= 254) begin
                    chk($sformatf("loop_done_pos n=%0d", n), 32'(k), 32'(9 + 6 * n));
                    chk($sformatf("loop_pass n=%0d", n), {24'd0, pass_cnt}, 32'((n + 1) % 256));
                end
                n++;
            end
            if (n < 257) tick();
        end
        chk("loop_done_count", 32'(n), 32'd257);
        tick();
        tick();
        chk("loop_in_ch", {28'd0, ch_sel}, 32'h2);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("loop_abort", obs(), pk(0, 0, 0, 0, 0, 1));

        // MANUAL, dwell 5: step in RST ignored, entry-cycle steps count
        mode      = 2'd2;
        dwell_cyc = 16'd5;
        start     = 1'b1;
        tick();
        start = 1'b0;
        chk("man_rst", obs(), pk(1, 0, 0, 1, 0, 0));
        step = 1'b1;
        tick();
        step = 1'b0;
        tick();
        tick();
        for (int w = 0; w < 8; w++)
            chk($sformatf("man_settle w=%0d", w), obs(), pk(0, 0, 0, 1, 0, 0));
        for (int s = 1; s <= 6; s++) begin
            for (int w = 0; w < ((s % 2 == 1) ? 8 : 0); w++) begin
                tick();
                if (s == 1)      chk($sformatf("man_hold s=%0d", s), obs(), pk(0, 0, 0, 1, 0, 0));
                else if (s <= 5) chk($sformatf("man_hold s=%0d", s), obs(), pk(0, 1 << (s - 2), s - 2, 1, 0, 0));
                else             chk($sformatf("man_hold s=%0d", s), obs(), pk(0, 0, 0, 1, 0, 0));
            end
            step = 1'b1;
            tick();
            step = 1'b0;
            if (s <= 4)      chk($sformatf("man_step s=%0d", s), obs(), pk(0, 1 << (s - 1), s - 1, 1, 0, 0));
            else if (s == 5) chk("man_step s=5", obs(), pk(0, 0, 0, 1, 0, 0));
            else             chk("man_step s=6", obs(), pk(0, 0, 0, 1, 1, 1));
        end
        tick();
        chk("man_idle", obs(), pk(0, 0, 0, 0, 0, 1));

        // Abort in CH idx=2 with simultaneous start
        mode      = 2'd0;
        dwell_cyc = 16'd3;
        start     = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 13; k++) tick();
        chk("abort_pre", obs(), pk(0, 4, 2, 1, 0, 0));
        abort = 1'b1;
        start = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        chk("abort_now", obs(), pk(0, 0, 0, 0, 0, 0));
        for (int k = 0; k < 5; k++) tick();
        chk("abort_stays_idle", obs(), pk(0, 0, 0, 0, 0, 0));
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("restart_rst", obs(), pk(1, 0, 0, 1, 0, 0));

        // Async reset mid-CH
        for (int k = 0; k < 8; k++) tick();
        chk("pre_async", obs(), pk(0, 1, 0, 1, 0, 0));
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset", obs(), pk(0, 0, 0, 0, 0, 0));
        tick();
        reset = 1'b0;
        tick();
        chk("post_async", obs(), pk(0, 0, 0, 0, 0, 0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
